// File: rtl/postfix_evaluator.sv
// rtl/postfix_evaluator.sv - evaluates a postfix token buffer with an internal operand stack
module postfix_evaluator #(
    parameter int STACK_DEPTH = 16,
    parameter int LOG_STACK   = 4
) (
    input  logic        CLK_1MHz,
    input  logic        RSTN,
    input  logic        start,
    input  logic [8:0]  top_addr_posf,
    output logic [8:0]  addr_posf_b,
    input  logic [35:0] do_posf_b,
    output logic        busy,
    output logic        finish,
    output logic [31:0] result,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0] OP_ADD = 9'h021;
    localparam logic [8:0] OP_SUB = 9'h022;
    localparam logic [8:0] OP_MUL = 9'h043;
    localparam logic [8:0] OP_DIV = 9'h044;

    localparam logic [LOG_STACK:0] SP_FULL = (LOG_STACK + 1)'(STACK_DEPTH);
    localparam logic [31:0]        INT_MIN = 32'h8000_0000;

    logic [1:0]           state;
    logic [8:0]           top;
    logic [LOG_STACK:0]   sp;
    logic [1:0]           err_pend;
    logic [31:0]          stack [STACK_DEPTH];

    logic                 is_opnd;
    logic [8:0]           opcode;
    logic [LOG_STACK-1:0] idx_b;
    logic [LOG_STACK-1:0] idx_a;
    logic [31:0]          opa;
    logic [31:0]          opb;
    logic [31:0]          alu_val;
    logic [1:0]           alu_err;
    logic [1:0]           exec_err;
    logic                 unused_bits;

    assign is_opnd     = ~do_posf_b[32];
    assign opcode      = do_posf_b[8:0];
    assign idx_b       = sp[LOG_STACK-1:0] - 1'b1;
    assign idx_a       = sp[LOG_STACK-1:0] - 2'd2;
    assign opa         = stack[idx_a];
    assign opb         = stack[idx_b];
    assign busy        = (state != S_IDLE);
    assign unused_bits = ^do_posf_b[35:33];

    always_comb begin
        alu_val = '0;
        alu_err = 2'd0;
        case (opcode)
            OP_ADD: alu_val = opa + opb;
            OP_SUB: alu_val = opa - opb;
            OP_MUL: alu_val = opa * opb;
            OP_DIV: begin
                if (opb == '0)
                    alu_err = 2'd3;
                else if (opa == INT_MIN && opb == 32'hFFFF_FFFF)
                    alu_val = INT_MIN;  // the one quotient that does not fit; wraps to itself
                else
                    alu_val = $signed(opa) / $signed(opb);
            end
            default: alu_err = 2'd1;
        endcase
    end

    always_comb begin
        exec_err = 2'd0;
        if (is_opnd)
            exec_err = (sp == SP_FULL) ? 2'd2 : 2'd0;
        else
            exec_err = (sp < 2) ? 2'd1 : alu_err;
    end

    // Stack storage carries no reset: contents are meaningless whenever sp says so.
    always_ff @(posedge CLK_1MHz) begin
        if (RSTN && state == S_EXEC && exec_err == 2'd0) begin
            if (is_opnd)
                stack[sp[LOG_STACK-1:0]] <= do_posf_b[31:0];
            else
                stack[idx_a] <= alu_val;
        end
    end

    always_ff @(posedge CLK_1MHz) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            top         <= '0;
            addr_posf_b <= '0;
            sp          <= '0;
            err_pend    <= '0;
            finish      <= 1'b0;
            result      <= '0;
            error       <= 1'b0;
            err_code    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        top         <= top_addr_posf;
                        addr_posf_b <= 9'd1;
                        sp          <= '0;
                        result      <= '0;
                        error       <= 1'b0;
                        err_code    <= '0;
                        if (top_addr_posf == 9'd0) begin
                            err_pend <= 2'd1;
                            state    <= S_DONE;
                        end else begin
                            err_pend <= 2'd0;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: state <= S_EXEC;
                S_EXEC: begin
                    if (exec_err != 2'd0) begin
                        err_pend <= exec_err;
                        state    <= S_DONE;
                    end else begin
                        sp <= is_opnd ? sp + 1'b1 : sp - 1'b1;
                        if (addr_posf_b == top) begin
                            state <= S_DONE;
                        end else begin
                            addr_posf_b <= addr_posf_b + 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the outcome, second drops finish and busy together.
                    if (!finish) begin
                        finish <= 1'b1;
                        if (err_pend != 2'd0) begin
                            error    <= 1'b1;
                            err_code <= err_pend;
                            result   <= '0;
                        end else if (sp == 1) begin
                            result <= stack[0];
                        end else begin
                            error    <= 1'b1;
                            err_code <= 2'd1;
                            result   <= '0;
                        end
                    end else begin
                        finish <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_postfix_evaluator.sv
// tb/tb_postfix_evaluator.sv - scoreboard bench for postfix_evaluator
`timescale 1ns/1ps
module tb_postfix_evaluator;

    logic        CLK_1MHz = 1'b0;
    logic        RSTN;
    logic        start;
    logic [8:0]  top_addr_posf;
    logic [8:0]  addr_posf_b;
    logic [35:0] do_posf_b;
    logic        busy;
    logic        finish;
    logic [31:0] result;
    logic        error;
    logic [1:0]  err_code;

    localparam logic [8:0] ADD = 9'h021;
    localparam logic [8:0] SUB = 9'h022;
    localparam logic [8:0] MUL = 9'h043;
    localparam logic [8:0] DIV = 9'h044;
    localparam logic [8:0] LPAR = 9'h150;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic [1:0]  code;
        int          fin_edge;
        int          last_addr;
    } exp_t;

    exp_t        sb[$];
    logic [35:0] mem [512];
    int          checks = 0;
    int          errors = 0;

    postfix_evaluator #(.STACK_DEPTH(16), .LOG_STACK(4)) dut (
        .CLK_1MHz     (CLK_1MHz),
        .RSTN         (RSTN),
        .start        (start),
        .top_addr_posf(top_addr_posf),
        .addr_posf_b  (addr_posf_b),
        .do_posf_b    (do_posf_b),
        .busy         (busy),
        .finish       (finish),
        .result       (result),
        .error        (error),
        .err_code     (err_code)
    );

    always #500 CLK_1MHz = ~CLK_1MHz;

    always @(posedge CLK_1MHz) do_posf_b <= mem[addr_posf_b];

    task automatic tick();
        @(posedge CLK_1MHz);
        #1;
    endtask

    function automatic logic [35:0] tn(input int v);
        logic [2:0] junk;
        junk = 3'($urandom_range(0, 7));
        return {junk, 1'b0, 32'(v)};
    endfunction

    function automatic logic [35:0] to(input logic [8:0] c);
        return {3'b000, 1'b1, 23'd0, c};
    endfunction

    task automatic load(input logic [35:0] toks[$]);
        for (int i = 0; i < 512; i++) mem[i] = 36'h1_0000_0155;
        for (int i = 0; i < toks.size(); i++) mem[i + 1] = toks[i];
    endtask

    task automatic expect_out(input logic [31:0] res, input logic err, input logic [1:0] code,
                              input int fin, input int last);
        exp_t e;
        e.res = res; e.err = err; e.code = code; e.fin_edge = fin; e.last_addr = last;
        sb.push_back(e);
    endtask

    task automatic run_and_check(input string tag, input logic [8:0] top, input int glitch_at);
        int          n;
        logic [8:0]  prev;
        logic [8:0]  alog[$];
        exp_t        e;
        logic        seq_ok;
        start = 1'b1;
        top_addr_posf = top;
        tick();
        start = 1'b0;
        checks++;
        if (result !== 32'd0 || error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s clear_at_e0 result=%0h error=%b code=%0d busy=%b required 0/0/0/1",
                     tag, result, error, err_code, busy);
        end
        alog.push_back(addr_posf_b);
        prev = addr_posf_b;
        n = 0;
        while (!finish && n < 100) begin
            start = (n == glitch_at);
            top_addr_posf = (n == glitch_at) ? 9'd2 : top;
            tick();
            start = 1'b0;
            n++;
            if (addr_posf_b !== prev) begin
                alog.push_back(addr_posf_b);
                prev = addr_posf_b;
            end
        end
        e = sb.pop_front();
        checks++;
        if (!finish) begin
            errors++;
            $display("FAIL %s timeout finish=%b required 1 within 100 cycles", tag, finish);
            return;
        end
        checks++;
        if (n != e.fin_edge) begin
            errors++;
            $display("FAIL %s finish_edge got e%0d required e%0d", tag, n, e.fin_edge);
        end
        checks++;
        if (result !== e.res || error !== e.err || err_code !== e.code) begin
            errors++;
            $display("FAIL %s outcome result=%0d error=%b code=%0d required %0d/%b/%0d",
                     tag, $signed(result), error, err_code, $signed(e.res), e.err, e.code);
        end
        seq_ok = (alog.size() == e.last_addr);
        for (int i = 0; i < alog.size(); i++) if (alog[i] !== 9'(i + 1)) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL %s addr_seq count=%0d last=%0d required 1..%0d",
                     tag, alog.size(), alog[alog.size() - 1], e.last_addr);
        end
        tick();
        checks++;
        if (finish !== 1'b0 || busy !== 1'b0 || result !== e.res || error !== e.err) begin
            errors++;
            $display("FAIL %s after_finish finish=%b busy=%b result=%0d error=%b required 0/0/%0d/%b",
                     tag, finish, busy, $signed(result), error, $signed(e.res), e.err);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; start = 1'b0; top_addr_posf = '0;
        load('{});
        repeat (3) tick();
        checks++;
        if (addr_posf_b !== 9'd0 || busy !== 1'b0 || finish !== 1'b0 || result !== 32'd0 ||
            error !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset addr=%0d busy=%b finish=%b result=%0h error=%b code=%0d required all 0",
                     addr_posf_b, busy, finish, result, error, err_code);
        end
        RSTN = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        load('{tn(3), tn(4), to(ADD), tn(2), to(MUL)});
        expect_out(32'd14, 1'b0, 2'd0, 11, 5);
        run_and_check("add_mul", 9'd5, -1);
        load('{tn(7), tn(-2), to(DIV)});
        expect_out(-32'sd3, 1'b0, 2'd0, 7, 3);
        run_and_check("div_trunc", 9'd3, -1);
        load('{tn(32'h8000_0000), tn(-1), to(DIV)});
        expect_out(32'h8000_0000, 1'b0, 2'd0, 7, 3);
        run_and_check("div_min", 9'd3, -1);
        load('{tn(65536), tn(65536), to(MUL)});
        expect_out(32'd0, 1'b0, 2'd0, 7, 3);
        run_and_check("mul_wrap", 9'd3, -1);
        load('{tn(8), tn(2), to(SUB)});
        expect_out(32'd6, 1'b0, 2'd0, 7, 3);
        run_and_check("sub_order", 9'd3, -1);
    endtask

    task automatic test_errors();
        load('{tn(5), tn(0), to(DIV)});
        expect_out(32'd0, 1'b1, 2'd3, 7, 3);
        run_and_check("div_zero", 9'd3, -1);
        load('{tn(3), to(ADD), tn(9)});
        expect_out(32'd0, 1'b1, 2'd1, 5, 2);
        run_and_check("underflow", 9'd3, -1);
        load('{tn(1), tn(2)});
        expect_out(32'd0, 1'b1, 2'd1, 5, 2);
        run_and_check("leftover", 9'd2, -1);
        load('{tn(1), tn(2), to(LPAR)});
        expect_out(32'd0, 1'b1, 2'd1, 7, 3);
        run_and_check("bad_op", 9'd3, -1);
        load('{});
        expect_out(32'd0, 1'b1, 2'd1, 1, 1);
        run_and_check("top_zero", 9'd0, -1);
    endtask

    task automatic test_overflow();
        logic [35:0] toks[$];
        for (int i = 0; i < 18; i++) toks.push_back(tn(i + 1));
        load(toks);
        expect_out(32'd0, 1'b1, 2'd2, 35, 17);
        run_and_check("overflow", 9'd18, -1);
    endtask

    task automatic test_start_ignored();
        load('{tn(3), tn(4), to(ADD), tn(2), to(MUL)});
        expect_out(32'd14, 1'b0, 2'd0, 11, 5);
        run_and_check("start_busy", 9'd5, 4);
    endtask

    task automatic test_reset_mid();
        load('{tn(3), tn(4), to(ADD), tn(2), to(MUL)});
        start = 1'b1; top_addr_posf = 9'd5;
        tick();
        start = 1'b0;
        tick();
        RSTN = 1'b0;
        tick();
        checks++;
        if (addr_posf_b !== 9'd0 || busy !== 1'b0 || finish !== 1'b0 || result !== 32'd0 ||
            error !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid addr=%0d busy=%b finish=%b result=%0h error=%b code=%0d required all 0",
                     addr_posf_b, busy, finish, result, error, err_code);
        end
        RSTN = 1'b1;
        tick();
        expect_out(32'd14, 1'b0, 2'd0, 11, 5);
        run_and_check("after_reset", 9'd5, -1);
    endtask

    task automatic test_back_to_back();
        load('{tn(8), tn(2), to(SUB)});
        expect_out(32'd6, 1'b0, 2'd0, 7, 3);
        run_and_check("b2b_first", 9'd3, -1);
        load('{tn(-20), tn(3), to(MUL)});
        expect_out(-32'sd60, 1'b0, 2'd0, 7, 3);
        run_and_check("b2b_second", 9'd3, -1);
    endtask

    task automatic test_random();
        int a, b, sel, r;
        logic [8:0] op;
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom);
            b = int'($urandom);
            sel = $urandom_range(0, 2);
            case (sel)
                0: begin op = ADD; r = a + b; end
                1: begin op = SUB; r = a - b; end
                default: begin op = MUL; r = a * b; end
            endcase
            load('{tn(a), tn(b), to(op)});
            expect_out(32'(r), 1'b0, 2'd0, 7, 3);
            run_and_check("random", 9'd3, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/postfix_evaluator.md
# postfix_evaluator

Reads the postfix token buffer produced by the infix-to-postfix arranger and evaluates it with an internal operand stack. It produces a 32-bit signed result, or an error code, for the calculator datapath. It sits downstream of the arranger and drives that block's postfix BRAM read port (`addr_posf_b` / `do_posf_b`). `start` is tied to the arranger's `finish`, and `top_addr_posf` is tied to the arranger's `top_addr_posf_a`.

## Interface
- `STACK_DEPTH`, default 16: number of operand stack entries, each 32 bits wide.
- `LOG_STACK`, default 4: log2 of `STACK_DEPTH`.
- `CLK_1MHz` in 1: system clock, rising edge.
- `RSTN` in 1: synchronous, active-low reset.
- `start` in 1: begin evaluation. Sampled only in `IDLE`.
- `top_addr_posf` in 9: address of the last valid token. Tokens occupy addresses 1..`top_addr_posf`, and address 0 is unused. Sampled with `start`.
- `addr_posf_b` out 9: postfix BRAM read address. The BRAM read is synchronous with 1-cycle latency.
- `do_posf_b` in 36: postfix BRAM read data.
- `busy` out 1: high in every state except `IDLE`.
- `finish` out 1: one-cycle pulse when evaluation ends, on success or on error.
- `result` out 32: signed result. Valid from the `finish` pulse until the next accepted `start`.
- `error` out 1: high when evaluation failed. Held like `result`.
- `err_code` out 2: 0 none, 1 malformed/underflow, 2 stack overflow, 3 divide by zero.

## Operation
- Token format:
  - `[32]=0`: operand. Value is `[31:0]`, two's complement.
  - `[32]=1`: operator, identified by `[8:0]`.
- Operator codes (`[7:5]` is the priority field):
  - ADD 9'h021
  - SUB 9'h022
  - MUL 9'h043
  - DIV 9'h044
  - Any other code, including parenthesis codes 9'h150/9'h151, is err 1.
- Bits `[35:33]` are ignored.
- States:
  - `IDLE`: `busy`=0. On `start`:
    - latch top, set `addr_posf_b`=1, clear stack pointer `sp`, `result`, `error` and `err_code`;
    - if top==0, go to `DONE` with `err_code`=1;
    - otherwise go to `FETCH`.
  - `FETCH`: BRAM samples `addr_posf_b`. Always go to `EXEC`.
  - `EXEC`: consume `do_posf_b`.
    - Operand: if `sp`==`STACK_DEPTH`, err 2; else push and `sp`+1.
    - Operator: if `sp`<2, err 1; else pop b (top), pop a, push a op b, `sp`-1.
    - If `addr_posf_b`==top, go to `DONE`; otherwise `addr_posf_b`+1 and go to `FETCH`.
    - Any error goes directly to `DONE` with `err_code` set. Remaining tokens are not read.
  - `DONE`:
    - no error and `sp`==1: `result`=stack[0];
    - no error and `sp`!=1: `error`=1, `err_code`=1, `result`=0;
    - any error: `result`=0.
    - Pulse `finish`, then return to `IDLE`.
- Arithmetic is 32-bit signed, wrap-around on overflow:
  - MUL keeps the low 32 bits of the product.
  - DIV truncates toward zero. -2^31 / -1 = -2^31.
  - DIV with b==0 is err 3.
- Operand order: a is the earlier-pushed value. For "8 2 -" the result is 6.
- `start` while `busy` is ignored. A new `start` in `IDLE` clears the previous result and error.
- Reset mid-operation aborts and returns to `IDLE` on the next edge. Stack contents become don't-care.

## Timing
- Reset values:
  - `addr_posf_b`=0, `busy`=0, `finish`=0, `result`=0, `error`=0, `err_code`=0, `sp`=0;
  - state is `IDLE`.
- Edge e0 samples `start`. Token k is consumed at edge e(2k). For an error-free N-token expression, `finish` is registered high at edge e(2N+1) and low at e(2N+2).
- `finish` and `busy` fall on the same edge. `start` may be reasserted in the cycle after `finish`.
- Error abort at token k: `finish` goes high at e(2k+1). For top==0: `finish` goes high at e1 via `DONE`, then e2.
- `result`, `error` and `err_code` change only at e0 (clear) and at the `DONE` edge.
- `addr_posf_b` changes only at e0 and at `EXEC` edges. It holds its last value in `IDLE`.

## Test plan
- "3 4 + 2 *" (5 tokens at addresses 1–5, top=5) -> `result`=14, `error`=0, `finish` pulse at e11 exactly one cycle wide. `addr_posf_b` sequence 1,2,3,4,5.
- "7 -2 /" (top=3) -> `result`=-3. "-2147483648 -1 /" -> `result`=-2147483648. "65536 65536 *" -> `result`=0. "8 2 -" -> 6.
- "5 0 /" -> `err_code`=3, `result`=0, `finish` at e7. "3 +" -> `err_code`=1 at e5. "1 2" -> `err_code`=1. top=0 -> `err_code`=1, `finish` at e1.
- 17 consecutive operands with `STACK_DEPTH`=16 -> `err_code`=2, `finish` at e35. Address 18 is never issued.
- `start` pulsed mid-evaluation -> ignored and result unchanged. `RSTN` low during `EXEC` -> next cycle is `IDLE` with all outputs at reset values. A following `start` evaluates correctly.
- Back-to-back: a second `start` the cycle after `finish` -> `result` clears at e0 and the new value appears at the new `DONE`.
